// File: rtl/seq_detector_param_if.sv
// Serial-bit detector bus: qualified bit stream and counter clear in, match pulse and count out.
interface seq_detector_param_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 in;
  logic                 in_valid;
  logic                 cnt_clear;
  logic                 out;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 count_sat;

  modport master (output in, in_valid, cnt_clear, input out, match_count, count_sat);
  modport slave  (input in, in_valid, cnt_clear, output out, match_count, count_sat);
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with registered match pulse and saturating match counter.
// Prefix-length transitions are built from PATTERN at elaboration (KMP failure function).
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     CNT_WIDTH   = 8
) (
  input logic                  clk,
  input logic                  R,
  seq_detector_param_if.slave  bus
);
  localparam int KW = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
  localparam int KN = 1 << KW;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  // Longest j such that (prefix_k ++ b) ends with prefix_j; a full match maps to 0 (hit path owns it).
  function automatic int next_k(input int k, input logic b);
    int   res, m;
    logic ok, sm;
    res = 0;
    for (int j = 1; j <= PATTERN_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < PATTERN_LEN; i++) begin
          if (i < j) begin
            m  = k + 1 - j + i;
            sm = (m < k) ? PATTERN[PATTERN_LEN-1-m] : b;
            if (sm != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
          end
        end
        if (ok) res = j;
      end
    end
    return (res >= PATTERN_LEN) ? 0 : res;
  endfunction

  function automatic int border_len();
    int   res;
    logic ok;
    res = 0;
    for (int j = 1; j < PATTERN_LEN; j++) begin
      ok = 1'b1;
      for (int i = 0; i < PATTERN_LEN; i++)
        if (i < j && PATTERN[j-1-i] != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
      if (ok) res = j;
    end
    return res;
  endfunction

  localparam logic [KW-1:0] K_MATCH = OVERLAP ? KW'(border_len()) : '0;

  logic [KW-1:0] nxt0 [KN];
  logic [KW-1:0] nxt1 [KN];

  for (genvar g = 0; g < KN; g++) begin : g_tbl
    localparam int N0 = (g < PATTERN_LEN) ? next_k(g, 1'b0) : 0;
    localparam int N1 = (g < PATTERN_LEN) ? next_k(g, 1'b1) : 0;
    assign nxt0[g] = KW'(N0);
    assign nxt1[g] = KW'(N1);
  end

  logic [KW-1:0]        k_q;
  logic                 out_q, sat_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic                 hit;

  assign hit     = bus.in_valid && (k_q == KW'(PATTERN_LEN-1)) && (bus.in == PATTERN[0]);
  assign cnt_nxt = (hit && cnt_q != CMAX) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (!R) begin
      k_q   <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      out_q <= hit;
      if (bus.in_valid)
        k_q <= hit ? K_MATCH : (bus.in ? nxt1[k_q] : nxt0[k_q]);
      // Clear wins over a coincident match; the pulse itself is unaffected.
      if (bus.cnt_clear) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        if (cnt_nxt == CMAX) sat_q <= 1'b1;
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench: five detector configurations share one stimulus stream.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic r = 1'b0, din = 1'b0, dval = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param_if                  b0();
  seq_detector_param_if                  b1();
  seq_detector_param_if #(.CNT_WIDTH(2)) b2();
  seq_detector_param_if                  b3();
  seq_detector_param_if                  b4();

  assign b0.in = din; assign b0.in_valid = dval; assign b0.cnt_clear = clr;
  assign b1.in = din; assign b1.in_valid = dval; assign b1.cnt_clear = clr;
  assign b2.in = din; assign b2.in_valid = dval; assign b2.cnt_clear = clr;
  assign b3.in = din; assign b3.in_valid = dval; assign b3.cnt_clear = clr;
  assign b4.in = din; assign b4.in_valid = dval; assign b4.cnt_clear = clr;

  seq_detector_param u0 (.clk(clk), .R(r), .bus(b0));
  seq_detector_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .R(r), .bus(b1));
  seq_detector_param #(.CNT_WIDTH(2)) u2 (.clk(clk), .R(r), .bus(b2));
  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1011)) u3 (.clk(clk), .R(r), .bus(b3));
  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1111)) u4 (.clk(clk), .R(r), .bus(b4));

  logic        o_a   [5];
  logic        sat_a [5];
  logic [31:0] cnt_a [5];

  assign o_a[0] = b0.out; assign sat_a[0] = b0.count_sat; assign cnt_a[0] = 32'(b0.match_count);
  assign o_a[1] = b1.out; assign sat_a[1] = b1.count_sat; assign cnt_a[1] = 32'(b1.match_count);
  assign o_a[2] = b2.out; assign sat_a[2] = b2.count_sat; assign cnt_a[2] = 32'(b2.match_count);
  assign o_a[3] = b3.out; assign sat_a[3] = b3.count_sat; assign cnt_a[3] = 32'(b3.match_count);
  assign o_a[4] = b4.out; assign sat_a[4] = b4.count_sat; assign cnt_a[4] = 32'(b4.match_count);

  typedef struct {
    int tid;
    bit r, d, v, c;
    int dut;
    bit eo;
    int ecnt;   // -1: not checked
    int esat;   // -1: not checked
  } vec_t;

  vec_t q[$];
  int   cur_t = 0;
  int   checks = 0;
  int   fails = 0;

  task automatic add(input bit rr, input bit d, input bit v, input bit c,
                     input int dut, input bit eo, input int ecnt, input int esat);
    vec_t e;
    e.tid = cur_t; e.r = rr; e.d = d; e.v = v; e.c = c;
    e.dut = dut; e.eo = eo; e.ecnt = ecnt; e.esat = esat;
    q.push_back(e);
  endtask

  // Accepted bit, normal operation.
  task automatic bit_in(input int dut, input bit d, input bit eo, input int ecnt = -1);
    add(1'b1, d, 1'b1, 1'b0, dut, eo, ecnt, -1);
  endtask

  task automatic rst(input int dut);
    add(1'b0, 1'b1, 1'b1, 1'b0, dut, 1'b0, 0, 0);
  endtask

  initial begin
    // 1: overlapping 101
    cur_t = 1; rst(0);
    bit_in(0, 1, 0); bit_in(0, 0, 0); bit_in(0, 1, 1, 1); bit_in(0, 0, 0, 1); bit_in(0, 1, 1, 2);
    // 2: non-overlapping 101
    cur_t = 2; rst(1);
    bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(1, 1, 1, 1); bit_in(1, 0, 0);
    bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(1, 1, 1, 2);
    // 3: gaps hold the partial match
    cur_t = 3; rst(0);
    bit_in(0, 1, 0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    bit_in(0, 0, 0); bit_in(0, 1, 1, 1);
    // 4: saturation at 2 bits, then clear coincident with a match
    cur_t = 4; rst(2);
    bit_in(2, 1, 0); bit_in(2, 0, 0);
    add(1'b1, 1, 1, 0, 2, 1, 1, 0); bit_in(2, 0, 0);
    add(1'b1, 1, 1, 0, 2, 1, 2, 0); bit_in(2, 0, 0);
    add(1'b1, 1, 1, 0, 2, 1, 3, 1); bit_in(2, 0, 0);
    add(1'b1, 1, 1, 0, 2, 1, 3, 1); bit_in(2, 0, 0, 3);
    add(1'b1, 1, 1, 1, 2, 1, 0, 0);
    add(1'b1, 0, 1, 0, 2, 0, 0, 0);
    // 5: reset mid-pattern overrides a would-be match and clears the count
    cur_t = 5; rst(0);
    bit_in(0, 1, 0); bit_in(0, 0, 0); bit_in(0, 1, 1, 1); bit_in(0, 0, 0, 1);
    rst(0);
    add(1'b1, 1, 1, 0, 0, 0, 0, 0);
    bit_in(0, 0, 0); bit_in(0, 1, 1, 1);
    // 6a: 1011 overlapping
    cur_t = 6; rst(3);
    bit_in(3, 1, 0); bit_in(3, 0, 0); bit_in(3, 1, 0); bit_in(3, 1, 1, 1);
    bit_in(3, 0, 0); bit_in(3, 1, 0); bit_in(3, 1, 1, 2);
    // 6b: 1111 with five ones
    cur_t = 7; rst(4);
    bit_in(4, 1, 0); bit_in(4, 1, 0); bit_in(4, 1, 0); bit_in(4, 1, 1, 1); bit_in(4, 1, 1, 2);
    bit_in(4, 0, 0, 2);

    for (int i = 0; i < q.size(); i++) begin
      r = q[i].r; din = q[i].d; dval = q[i].v; clr = q[i].c;
      @(posedge clk);
      #1;
      checks++;
      if (o_a[q[i].dut] !== q[i].eo) begin
        fails++;
        $display("FAIL t%0d v%0d dut%0d out act=%0b exp=%0b", q[i].tid, i, q[i].dut,
                 o_a[q[i].dut], q[i].eo);
      end
      if (q[i].ecnt >= 0) begin
        checks++;
        if (cnt_a[q[i].dut] !== 32'(q[i].ecnt)) begin
          fails++;
          $display("FAIL t%0d v%0d dut%0d match_count act=%0d exp=%0d", q[i].tid, i, q[i].dut,
                   cnt_a[q[i].dut], q[i].ecnt);
        end
      end
      if (q[i].esat >= 0) begin
        checks++;
        if (sat_a[q[i].dut] !== q[i].esat[0]) begin
          fails++;
          $display("FAIL t%0d v%0d dut%0d count_sat act=%0b exp=%0d", q[i].tid, i, q[i].dut,
                   sat_a[q[i].dut], q[i].esat);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
